// File: rtl/cpu_sequencer_pkg.sv
// cpu_sequencer_pkg: opcodes, ALU codes, FSM states and the EXEC control decode
package cpu_sequencer_pkg;

  localparam logic [3:0] OP_JC    = 4'd0;
  localparam logic [3:0] OP_JNC   = 4'd1;
  localparam logic [3:0] OP_CMPI  = 4'd2;
  localparam logic [3:0] OP_CMPM  = 4'd3;
  localparam logic [3:0] OP_LIT   = 4'd4;
  localparam logic [3:0] OP_IN    = 4'd5;
  localparam logic [3:0] OP_LD    = 4'd6;
  localparam logic [3:0] OP_ST    = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;
  localparam logic [3:0] OP_JNZ   = 4'd9;
  localparam logic [3:0] OP_ADDI  = 4'd10;
  localparam logic [3:0] OP_ADDM  = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_OUT   = 4'd13;
  localparam logic [3:0] OP_NANDI = 4'd14;
  localparam logic [3:0] OP_NANDM = 4'd15;

  localparam logic [2:0] F_PASS_A = 3'b000;
  localparam logic [2:0] F_SUB    = 3'b001;
  localparam logic [2:0] F_PASS_B = 3'b010;
  localparam logic [2:0] F_ADD    = 3'b011;
  localparam logic [2:0] F_NAND   = 3'b100;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       enable_counter;
    logic       load_counter;
    logic       enable_accu;
    logic       enable_flags;
    logic [2:0] f;
    logic       cs;
    logic       we;
    logic       enable_bus2;
    logic       enable_in;
    logic       enable_bus1;
    logic       enable_out;
  } ctrl_t;

  function automatic ctrl_t exec_ctrl(input logic [3:0] op, input logic c, input logic z);
    ctrl_t k;
    logic taken;
    logic two;
    k = '0;
    taken = op == OP_JMP || (op == OP_JC && c) || (op == OP_JNC && !c) ||
            (op == OP_JZ && z) || (op == OP_JNZ && !z);
    two = op inside {OP_JC, OP_JNC, OP_CMPM, OP_LD, OP_ST, OP_JZ, OP_JNZ, OP_ADDM, OP_JMP, OP_NANDM};
    k.load_counter   = taken;
    k.enable_counter = two && !taken;
    k.enable_bus1    = op inside {OP_CMPI, OP_LIT, OP_ADDI, OP_NANDI};
    k.cs             = op inside {OP_CMPM, OP_LD, OP_ADDM, OP_NANDM, OP_ST};
    k.we             = op == OP_ST;
    k.enable_bus2    = op == OP_ST || op == OP_OUT;
    k.enable_out     = op == OP_OUT;
    k.enable_in      = op == OP_IN;
    k.enable_accu    = op inside {OP_IN, OP_LIT, OP_LD, OP_ADDI, OP_ADDM, OP_NANDI, OP_NANDM};
    k.enable_flags   = op inside {OP_CMPI, OP_CMPM, OP_ADDI, OP_ADDM, OP_NANDI, OP_NANDM};
    k.f = op inside {OP_IN, OP_LIT, OP_LD} ? F_PASS_B :
          op inside {OP_CMPI, OP_CMPM}     ? F_SUB :
          op inside {OP_ADDI, OP_ADDM}     ? F_ADD :
          op inside {OP_NANDI, OP_NANDM}   ? F_NAND : F_PASS_A;
    return k;
  endfunction

endpackage

// File: rtl/cpu_sequencer_sync_edge.sv
// cpu_sequencer_sync_edge: N-stage synchronisers for run and step plus a step rising-edge pulse
module cpu_sequencer_sync_edge #(
  parameter int N = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  input  logic step,
  output logic run_sync,
  output logic step_rise
);

  logic [N-1:0] run_q;
  logic [N-1:0] step_q;
  logic         step_prev;

  // shift both asynchronous inputs through the chain and remember the last synced step level
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_q     <= '0;
      step_q    <= '0;
      step_prev <= 1'b0;
    end else begin
      run_q     <= {run_q[N-2:0], run};
      step_q    <= {step_q[N-2:0], step};
      step_prev <= step_q[N-1];
    end
  end

  assign run_sync  = run_q[N-1];
  assign step_rise = step_q[N-1] & ~step_prev;

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute/halt control FSM driving every datapath enable
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter logic START_HALTED = 1'b0,
  parameter int   SYNC_STAGES  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] instr,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       phase,
  output logic       halted,
  output logic       fetch_en,
  output logic       enable_counter,
  output logic       load_counter,
  output logic       enable_accu,
  output logic       enable_flags,
  output logic [2:0] f,
  output logic       cs,
  output logic       we,
  output logic       enable_bus2,
  output logic       enable_in,
  output logic       enable_bus1,
  output logic       enable_out
);

  state_t state;
  state_t state_nxt;
  ctrl_t  ctrl;
  ctrl_t  ctrl_out;
  logic   run_sync;
  logic   step_rise;
  logic   fetch_c;
  logic   phase_c;

  cpu_sequencer_sync_edge #(.N(SYNC_STAGES)) u_sync (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .run_sync  (run_sync),
    .step_rise (step_rise)
  );

  // state register; reset lands in HALT or FETCH depending on START_HALTED
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= START_HALTED ? S_HALT : S_FETCH;
    else state <= state_nxt;
  end

  // next state and raw control decode from the current state and opcode
  always_comb begin
    state_nxt = state;
    ctrl      = '0;
    fetch_c   = 1'b0;
    phase_c   = 1'b0;
    case (state)
      S_FETCH: begin
        fetch_c             = 1'b1;
        ctrl.enable_counter = 1'b1;
        state_nxt           = S_EXEC;
      end
      S_EXEC: begin
        phase_c   = 1'b1;
        ctrl      = exec_ctrl(instr, c_flag, z_flag);
        state_nxt = run_sync ? S_FETCH : S_HALT;
      end
      S_HALT:  state_nxt = (run_sync || step_rise) ? S_FETCH : S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  assign ctrl_out       = reset ? '0 : ctrl;
  assign phase          = phase_c & ~reset;
  assign fetch_en       = fetch_c & ~reset;
  assign halted         = reset ? START_HALTED : state == S_HALT;
  assign enable_counter = ctrl_out.enable_counter;
  assign load_counter   = ctrl_out.load_counter;
  assign enable_accu    = ctrl_out.enable_accu;
  assign enable_flags   = ctrl_out.enable_flags;
  assign f              = ctrl_out.f;
  assign cs             = ctrl_out.cs;
  assign we             = ctrl_out.we;
  assign enable_bus2    = ctrl_out.enable_bus2;
  assign enable_in      = ctrl_out.enable_in;
  assign enable_bus1    = ctrl_out.enable_bus1;
  assign enable_out     = ctrl_out.enable_out;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed and random checks of the sequencer against a behavioural model
module tb_cpu_sequencer;

  localparam int S  = 2;
  localparam int SH = 3;
  localparam logic [15:0] TWO   = 16'h9BCB;
  localparam logic [15:0] IMM   = 16'h4414;
  localparam logic [15:0] MEMRD = 16'h8848;
  localparam logic [15:0] ACCU  = 16'hCC70;
  localparam logic [15:0] FLAGS = 16'hCC0C;
  localparam logic [47:0] F_TAB = {3'd4, 3'd4, 3'd0, 3'd0, 3'd3, 3'd3, 3'd0, 3'd0,
                                   3'd0, 3'd2, 3'd2, 3'd2, 3'd1, 3'd1, 3'd0, 3'd0};

  logic clock = 1'b0, reset = 1'b1, run = 1'b0, step = 1'b0, run_h = 1'b0;
  logic [3:0] instr = 4'd0;
  logic c_flag = 1'b0, z_flag = 1'b0;

  logic phase, halted, fetch_en, enable_counter, load_counter, enable_accu, enable_flags;
  logic cs, we, enable_bus2, enable_in, enable_bus1, enable_out;
  logic [2:0] f;
  logic h_phase, h_halted, h_fetch_en, h_enable_counter, h_load_counter, h_enable_accu, h_enable_flags;
  logic h_cs, h_we, h_enable_bus2, h_enable_in, h_enable_bus1, h_enable_out;
  logic [2:0] h_f;

  always #5 clock = ~clock;

  cpu_sequencer #(.START_HALTED(1'b0), .SYNC_STAGES(S)) dut (
    .clock(clock), .reset(reset), .run(run), .step(step), .instr(instr),
    .c_flag(c_flag), .z_flag(z_flag), .phase(phase), .halted(halted), .fetch_en(fetch_en),
    .enable_counter(enable_counter), .load_counter(load_counter), .enable_accu(enable_accu),
    .enable_flags(enable_flags), .f(f), .cs(cs), .we(we), .enable_bus2(enable_bus2),
    .enable_in(enable_in), .enable_bus1(enable_bus1), .enable_out(enable_out)
  );

  cpu_sequencer #(.START_HALTED(1'b1), .SYNC_STAGES(SH)) dut_h (
    .clock(clock), .reset(reset), .run(run_h), .step(1'b0), .instr(instr),
    .c_flag(c_flag), .z_flag(z_flag), .phase(h_phase), .halted(h_halted), .fetch_en(h_fetch_en),
    .enable_counter(h_enable_counter), .load_counter(h_load_counter), .enable_accu(h_enable_accu),
    .enable_flags(h_enable_flags), .f(h_f), .cs(h_cs), .we(h_we), .enable_bus2(h_enable_bus2),
    .enable_in(h_enable_in), .enable_bus1(h_enable_bus1), .enable_out(h_enable_out)
  );

  wire logic [15:0] obs = {phase, halted, fetch_en, enable_counter, load_counter, enable_accu,
                           enable_flags, f, cs, we, enable_bus2, enable_in, enable_bus1, enable_out};
  wire logic [15:0] h_obs = {h_phase, h_halted, h_fetch_en, h_enable_counter, h_load_counter,
                             h_enable_accu, h_enable_flags, h_f, h_cs, h_we, h_enable_bus2,
                             h_enable_in, h_enable_bus1, h_enable_out};

  typedef enum {M_FETCH, M_EXEC, M_HALT} mode_t;
  mode_t mode = M_FETCH;
  bit in_rst = 1'b1;
  logic rq[$];
  logic sq[$];
  int n_assert = 0, n_fail = 0;
  int h_edges = 0, h_lat = -1;
  int fetch_cnt;

  function automatic logic [15:0] expect_vec();
    logic [15:0] v;
    logic tk;
    int op;
    v = '0;
    op = int'(instr);
    if (in_rst) return v;
    if (mode == M_FETCH) begin
      v[13] = 1'b1;
      v[12] = 1'b1;
      return v;
    end
    if (mode == M_HALT) begin
      v[14] = 1'b1;
      return v;
    end
    tk = op == 12 || (op == 0 && c_flag) || (op == 1 && !c_flag) || (op == 8 && z_flag) || (op == 9 && !z_flag);
    v[15]  = 1'b1;
    v[12]  = TWO[op] && !tk;
    v[11]  = tk;
    v[10]  = ACCU[op];
    v[9]   = FLAGS[op];
    v[8:6] = F_TAB[op*3 +: 3];
    v[5]   = MEMRD[op] || op == 7;
    v[4]   = op == 7;
    v[3]   = op == 7 || op == 13;
    v[2]   = op == 5;
    v[1]   = IMM[op];
    v[0]   = op == 13;
    return v;
  endfunction

  task automatic model_reset();
    mode = M_FETCH;
    rq.delete();
    sq.delete();
  endtask

  task automatic model_edge();
    logic rs, sr;
    rs = rq.size() > S - 1 ? rq[S-1] : 1'b0;
    sr = (sq.size() > S - 1 ? sq[S-1] : 1'b0) & ~(sq.size() > S ? sq[S] : 1'b0);
    if (mode == M_FETCH) mode = M_EXEC;
    else if (mode == M_EXEC) mode = rs ? M_FETCH : M_HALT;
    else mode = (rs || sr) ? M_FETCH : M_HALT;
    rq.push_front(run);
    sq.push_front(step);
    if (rq.size() > S + 2) begin
      void'(rq.pop_back());
      void'(sq.pop_back());
    end
  endtask

  task automatic check(input string tag);
    logic [15:0] e;
    e = expect_vec();
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (mode %s instr %0d c %b z %b)", tag, obs, e, mode.name(), instr, c_flag, z_flag);
    end
    n_assert++;
    assert ($countones({enable_bus2, enable_in, enable_bus1}) <= 1) else begin
      n_fail++;
      $error("FAIL %s_bus_onehot: observed %b expected at most one set", tag, {enable_bus2, enable_in, enable_bus1});
    end
    n_assert++;
    assert (!we || (phase && instr == 4'd7)) else begin
      n_fail++;
      $error("FAIL %s_we_only_st: observed we=%b instr=%0d expected we only for ST", tag, we, instr);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clock);
    if (!in_rst) model_edge();
    h_edges++;
    @(negedge clock);
    if (h_lat < 0 && !in_rst && !h_halted) h_lat = h_edges;
    check(tag);
  endtask

  task automatic wait_mode(input mode_t m, input string tag);
    for (int k = 0; k < 10 && mode != m; k++) cycle(tag);
    n_assert++;
    assert ((m == M_EXEC) ? phase === 1'b1 : halted === 1'b1) else begin
      n_fail++;
      $error("FAIL %s_reach: observed phase=%b halted=%b expected state %s", tag, phase, halted, m.name());
    end
  endtask

  task automatic release_reset();
    reset = 1'b0;
    in_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2;
    check("reset_state");
    n_assert++;
    assert (h_obs === 16'h4000) else begin
      n_fail++;
      $error("FAIL reset_h: observed %h expected %h", h_obs, 16'h4000);
    end
    repeat (2) cycle("reset_hold");
    release_reset();
    #1;
    check("post_reset_fetch");
    n_assert++;
    assert (h_obs === 16'h4000) else begin
      n_fail++;
      $error("FAIL start_halted: observed %h expected %h", h_obs, 16'h4000);
    end
    run = 1'b1;
    run_h = 1'b1;
    h_edges = 0;
    instr = 4'd4;
    cycle("lit_exec");
    n_assert++;
    assert ({phase, enable_bus1, f, enable_accu, enable_counter} === 7'b1_1_010_1_0) else begin
      n_fail++;
      $error("FAIL lit_exec_fields: observed %b expected %b", {phase, enable_bus1, f, enable_accu, enable_counter}, 7'b1101010);
    end
    repeat (6) cycle("warmup");
    n_assert++;
    assert (h_lat > 0 && h_lat <= SH + 1) else begin
      n_fail++;
      $error("FAIL start_halted_run_latency: observed %0d expected 1..%0d", h_lat, SH + 1);
    end

    instr = 4'd8;
    z_flag = 1'b1;
    wait_mode(M_EXEC, "jz_taken");
    n_assert++;
    assert ({load_counter, enable_counter} === 2'b10) else begin
      n_fail++;
      $error("FAIL jz_taken: observed %b expected %b", {load_counter, enable_counter}, 2'b10);
    end
    cycle("jz_gap");
    z_flag = 1'b0;
    wait_mode(M_EXEC, "jz_not_taken");
    n_assert++;
    assert ({load_counter, enable_counter} === 2'b01) else begin
      n_fail++;
      $error("FAIL jz_not_taken: observed %b expected %b", {load_counter, enable_counter}, 2'b01);
    end

    cycle("st_gap");
    instr = 4'd7;
    wait_mode(M_EXEC, "st_exec");
    n_assert++;
    assert ({cs, we, enable_bus2, f} === 6'b111_000) else begin
      n_fail++;
      $error("FAIL st_exec: observed %b expected %b", {cs, we, enable_bus2, f}, 6'b111000);
    end
    #1;
    reset = 1'b1;
    in_rst = 1'b1;
    #1;
    check("st_reset_async");
    cycle("st_reset_hold");
    release_reset();
    #1;
    check("st_after_reset");

    run = 1'b0;
    instr = 4'd10;
    wait_mode(M_HALT, "halt_enter");
    for (int i = 0; i < 20; i++) cycle("halt_idle");
    fetch_cnt = 0;
    step = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("step_high");
      fetch_cnt += int'(fetch_en);
    end
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle("step_low");
      fetch_cnt += int'(fetch_en);
    end
    n_assert++;
    assert (fetch_cnt == 1 && halted === 1'b1) else begin
      n_fail++;
      $error("FAIL single_step: observed fetches=%0d halted=%b expected 1 fetch then halted=1", fetch_cnt, halted);
    end

    run = 1'b1;
    for (int op = 0; op < 16; op++) begin
      for (int fl = 0; fl < 4; fl++) begin
        instr = 4'(op);
        {c_flag, z_flag} = 2'(fl);
        cycle("sweep");
        cycle("sweep");
      end
    end

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step = $urandom_range(0, 3) == 0;
      instr = 4'($urandom_range(0, 15));
      c_flag = 1'($urandom_range(0, 1));
      z_flag = 1'($urandom_range(0, 1));
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
